femto_mem_arbiter: RTL and testbench
====================================

// Module: femto_mem_arbiter
// PURPOSE
//  Shares the single FemtoRV32 memory port (28b addr, 2b read_n/write_n size codes, ready handshake)
//  between two requesters: master 0 = CPU core, master 1 = DMA/debug engine.
//  Grants round-robin, registers the winning command and holds it stable to the downstream bus until
//  ds_ready. Routes rdata/ready back to the owner only. A timeout aborts hung transactions.
// PARAMETERS
//  ADDR_WIDTH    28    address width, all ports
//  TIMEOUT_CYC   255   max cycles a command may wait for ds_ready; 0 disables timeout
//  M0_PRIORITY   0     1 = master 0 always wins contention (fixed priority); 0 = round-robin
// PORTS
//  clk          in   1     single clock, rising edge
//  resetn       in   1     asynchronous, active-low reset
//  m0_addr      in   28    master 0 address
//  m0_wdata     in   32    master 0 write data
//  m0_read_n    in   2     11 none, 00 byte, 01 half, 10 word
//  m0_write_n   in   2     same encoding as read_n
//  m0_rdata     out  32    read data to master 0
//  m0_ready     out  1     1-cycle completion pulse to master 0
//  m1_*         -    -     identical set for master 1
//  ds_addr      out  28    registered downstream address
//  ds_wdata     out  32    registered downstream write data
//  ds_read_n    out  2     registered downstream read size
//  ds_write_n   out  2     registered downstream write size
//  ds_rdata     in   32    downstream read data, valid with ds_ready
//  ds_ready     in   1     downstream completion
//  busy         out  1     command outstanding downstream
//  owner        out  1     master owning current/last command
//  timeout_err  out  1     sticky; set on timeout, cleared only by reset
// BEHAVIOUR
//  Reset: state IDLE, ds_read_n=ds_write_n=11, ds_addr/ds_wdata=0, m*_ready=0, m*_rdata=0, busy=0,
//   owner=1 (so master 0 wins first round-robin tie), timeout_err=0, timeout counter=0.
//  Request: mX_req = (mX_read_n!=11)|(mX_write_n!=11). Both non-11: write wins, read ignored.
//  States: IDLE -> BUSY -> IDLE. No separate abort state.
//  IDLE: no req -> stay. Any req -> grant winner, latch addr/wdata/sizes into ds_* regs, owner<=winner,
//   busy<=1, counter<=0, go BUSY. Earliest ds_ready is the cycle after the request is first seen.
//  Arbitration: single req -> that master. Both requesting: M0_PRIORITY=1 -> m0; else the master
//   that is not 'owner' (last grant).
//  BUSY: ds_* held constant. ds_ready=1 -> owner's mX_ready=1 for exactly that cycle,
//   mX_rdata=ds_rdata (combinational pass-through), ds_read_n/ds_write_n<=11, busy<=0, go IDLE.
//   The non-owner's ready is always 0; its rdata is 0.
//  Dead cycle: IDLE always sits >=1 cycle after completion; masters drop req on ready, so a finished
//   request is never re-granted. Back-to-back throughput: one command per (latency+1) cycles.
//  Owner drops req while BUSY: command still completes downstream; ready/rdata are not forwarded.
//  Timeout (TIMEOUT_CYC>0): counter increments each BUSY cycle without ds_ready. Reaching TIMEOUT_CYC
//   -> owner ready pulse with rdata=32'h0, timeout_err<=1, ds_* sizes<=11, go IDLE. ds_ready on that
//   same cycle takes precedence: normal completion, no error.
//  Counter width = $clog2(TIMEOUT_CYC+1); saturates, never wraps.
//  Asynchronous reset mid-BUSY abandons the command immediately; downstream sees sizes 11 at once.
//  Inputs are sampled only in IDLE; changes on m*_addr/wdata during BUSY have no effect.
// STRUCTURE
//  Package femto_bus_pkg: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_NONE=2'b11;
//   ARB_IDLE/ARB_BUSY state encodings; bus command struct {addr, wdata, read_n, write_n}.
//  Single module; the 2-way winner logic is small enough to be inline -- no sub-module.
// TESTING
//  1 m0 word read 0x0000100, ds_ready 3 cycles later, ds_rdata=0xDEADBEEF -> m0_ready 1 cycle,
//    m0_rdata=0xDEADBEEF, m1_ready=0, ds_read_n=11 next cycle.
//  2 m0 and m1 request in the same cycle, 4 back-to-back rounds (M0_PRIORITY=0) -> grants m0,m1,m0,m1;
//    with M0_PRIORITY=1 -> m0 every round while m0 keeps requesting.
//  3 m1 byte write 0x0000040 data 0xA5 held; change m1_addr mid-BUSY -> ds_addr stays 0x0000040,
//    ds_write_n=00 until ds_ready.
//  4 TIMEOUT_CYC=8, ds_ready never asserted -> owner ready on 8th BUSY cycle, rdata=0, timeout_err=1;
//    ds_ready on exactly that cycle -> normal completion, timeout_err stays 0.
//  5 resetn low during BUSY -> ds_read_n/ds_write_n=11 and busy=0 immediately; after release,
//    first m0 request is granted cleanly.

Source files
------------

// File: rtl/femto_bus_pkg.sv
// Shared definitions for the FemtoRV32 memory bus: size codes, arbiter
// state encodings and a bundled command record.
package femto_bus_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_NONE = 2'b11;

  localparam int BUS_ADDR_W = 28;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
    logic [1:0]            read_n;
    logic [1:0]            write_n;
  } bus_cmd_t;

  // A master is requesting whenever either size code is something other than "none".
  function automatic logic is_req(input logic [1:0] read_n, input logic [1:0] write_n);
    return (read_n != SZ_NONE) || (write_n != SZ_NONE);
  endfunction

endpackage

// File: rtl/femto_mem_arbiter.sv
// Two-master arbiter for the FemtoRV32 memory port. Master 0 is the CPU,
// master 1 the DMA/debug engine. The winning command is registered and held
// on the downstream bus until ds_ready or until the timeout gives up on it.
module femto_mem_arbiter
  import femto_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 28,
  parameter int TIMEOUT_CYC = 255,
  parameter int M0_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [1:0]            m0_read_n,
  input  logic [1:0]            m0_write_n,
  output logic [31:0]           m0_rdata,
  output logic                  m0_ready,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [1:0]            m1_read_n,
  input  logic [1:0]            m1_write_n,
  output logic [31:0]           m1_rdata,
  output logic                  m1_ready,
  output logic [ADDR_WIDTH-1:0] ds_addr,
  output logic [31:0]           ds_wdata,
  output logic [1:0]            ds_read_n,
  output logic [1:0]            ds_write_n,
  input  logic [31:0]           ds_rdata,
  input  logic                  ds_ready,
  output logic                  busy,
  output logic                  owner,
  output logic                  timeout_err
);

  // A zero timeout still needs a legal one-bit counter even though it is never consulted.
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_SAT = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC) : {CNT_W{1'b1}};

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;

  logic m0_req;
  logic m1_req;
  logic grant_m1;
  logic owner_req;
  logic timeout_hit;
  logic done;
  logic forward;

  // Request decode, winner selection and completion detection.
  always_comb begin
    m0_req      = is_req(m0_read_n, m0_write_n);
    m1_req      = is_req(m1_read_n, m1_write_n);
    // On contention m1 only wins under round-robin when m0 held the last grant.
    grant_m1    = m1_req && (!m0_req || ((M0_PRIORITY == 0) && (owner == 1'b0)));
    owner_req   = owner ? m1_req : m0_req;
    // The cycle that would push the counter to the limit is the one that gives up.
    timeout_hit = (TIMEOUT_CYC != 0) && (state == ARB_BUSY) && !ds_ready &&
                  ((int'(cnt) + 1) >= TIMEOUT_CYC);
    done        = (state == ARB_BUSY) && (ds_ready || timeout_hit);
    forward     = done && owner_req;
  end

  // Completion is routed only to the owner, and only while it still wants the answer.
  always_comb begin
    m0_ready = forward && (owner == 1'b0);
    m1_ready = forward && (owner == 1'b1);
    m0_rdata = (m0_ready && ds_ready) ? ds_rdata : 32'h0;
    m1_rdata = (m1_ready && ds_ready) ? ds_rdata : 32'h0;
  end

  // Arbiter FSM: latch the winner's command in IDLE, hold it in BUSY until done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ARB_IDLE;
      ds_addr     <= '0;
      ds_wdata    <= '0;
      ds_read_n   <= SZ_NONE;
      ds_write_n  <= SZ_NONE;
      busy        <= 1'b0;
      owner       <= 1'b1;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (m0_req || m1_req) begin
            ds_addr    <= grant_m1 ? m1_addr : m0_addr;
            ds_wdata   <= grant_m1 ? m1_wdata : m0_wdata;
            ds_write_n <= grant_m1 ? m1_write_n : m0_write_n;
            // A write present alongside a read wins; the read half is dropped.
            if (grant_m1)
              ds_read_n <= (m1_write_n != SZ_NONE) ? SZ_NONE : m1_read_n;
            else
              ds_read_n <= (m0_write_n != SZ_NONE) ? SZ_NONE : m0_read_n;
            owner <= grant_m1;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (ds_ready || timeout_hit) begin
            ds_read_n  <= SZ_NONE;
            ds_write_n <= SZ_NONE;
            busy       <= 1'b0;
            state      <= ARB_IDLE;
            if (!ds_ready)
              timeout_err <= 1'b1;
          end else if (cnt != CNT_SAT) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_femto_mem_arbiter.sv
// Directed bench for femto_mem_arbiter: a round-robin and fixed-priority
// instance share the same stimulus, followed by hand-written corner sequences.
module tb_femto_mem_arbiter;

  logic        clk;
  logic        resetn;
  logic [27:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [1:0]  m0_read_n, m0_write_n, m1_read_n, m1_write_n;
  logic [31:0] ds_rdata;
  logic        ds_ready;

  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic [27:0] ds_addr;
  logic [31:0] ds_wdata;
  logic [1:0]  ds_read_n, ds_write_n;
  logic        busy, owner, timeout_err;

  logic [31:0] p_m0_rdata, p_m1_rdata;
  logic        p_m0_ready, p_m1_ready;
  logic [27:0] p_ds_addr;
  logic [31:0] p_ds_wdata;
  logic [1:0]  p_ds_read_n, p_ds_write_n;
  logic        p_busy, p_owner, p_timeout_err;

  int errors = 0;
  int checks = 0;

  femto_mem_arbiter #(.ADDR_WIDTH(28), .TIMEOUT_CYC(8), .M0_PRIORITY(0)) dut (
    .clk(clk), .resetn(resetn),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_read_n(m0_read_n), .m0_write_n(m0_write_n),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_read_n(m1_read_n), .m1_write_n(m1_write_n),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .ds_addr(ds_addr), .ds_wdata(ds_wdata), .ds_read_n(ds_read_n), .ds_write_n(ds_write_n),
    .ds_rdata(ds_rdata), .ds_ready(ds_ready),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  femto_mem_arbiter #(.ADDR_WIDTH(28), .TIMEOUT_CYC(8), .M0_PRIORITY(1)) dut_p (
    .clk(clk), .resetn(resetn),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_read_n(m0_read_n), .m0_write_n(m0_write_n),
    .m0_rdata(p_m0_rdata), .m0_ready(p_m0_ready),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_read_n(m1_read_n), .m1_write_n(m1_write_n),
    .m1_rdata(p_m1_rdata), .m1_ready(p_m1_ready),
    .ds_addr(p_ds_addr), .ds_wdata(p_ds_wdata), .ds_read_n(p_ds_read_n), .ds_write_n(p_ds_write_n),
    .ds_rdata(ds_rdata), .ds_ready(ds_ready),
    .busy(p_busy), .owner(p_owner), .timeout_err(p_timeout_err)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  m0_rn;
    logic [1:0]  m1_rn;
    logic        rdy;
    logic        exp_busy;
    logic        exp_owner;
    logic        exp_m0_ready;
    logic        exp_m1_ready;
    logic        exp_p_owner;
    logic        exp_p_m0_ready;
    logic        exp_p_m1_ready;
    logic [1:0]  exp_ds_read_n;
    logic [27:0] exp_ds_addr;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    m0_read_n = v.m0_rn;
    m1_read_n = v.m1_rn;
    ds_ready  = v.rdy;
  endtask

  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(v.exp_busy));
    checkOutput($sformatf("vec%0d owner", i), 32'(owner), 32'(v.exp_owner));
    checkOutput($sformatf("vec%0d m0_ready", i), 32'(m0_ready), 32'(v.exp_m0_ready));
    checkOutput($sformatf("vec%0d m1_ready", i), 32'(m1_ready), 32'(v.exp_m1_ready));
    checkOutput($sformatf("vec%0d ds_read_n", i), 32'(ds_read_n), 32'(v.exp_ds_read_n));
    checkOutput($sformatf("vec%0d ds_addr", i), 32'(ds_addr), 32'(v.exp_ds_addr));
    checkOutput($sformatf("vec%0d prio busy", i), 32'(p_busy), 32'(v.exp_busy));
    checkOutput($sformatf("vec%0d prio owner", i), 32'(p_owner), 32'(v.exp_p_owner));
    checkOutput($sformatf("vec%0d prio m0_ready", i), 32'(p_m0_ready), 32'(v.exp_p_m0_ready));
    checkOutput($sformatf("vec%0d prio m1_ready", i), 32'(p_m1_ready), 32'(v.exp_p_m1_ready));
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleMasters();
    m0_read_n  = 2'b11; m0_write_n = 2'b11;
    m1_read_n  = 2'b11; m1_write_n = 2'b11;
  endtask

  // Main directed sequence.
  initial begin
    //              m0   m1   rdy busy own m0r m1r pown pm0r pm1r dsrn   ds_addr
    vecs[0]  = '{2'b10, 2'b10, 0, 0, 1, 0, 0, 1, 0, 0, 2'b11, 28'h0};
    vecs[1]  = '{2'b10, 2'b10, 1, 1, 0, 1, 0, 0, 1, 0, 2'b10, 28'h10};
    vecs[2]  = '{2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 28'h10};
    vecs[3]  = '{2'b10, 2'b10, 1, 1, 1, 0, 1, 0, 1, 0, 2'b10, 28'h20};
    vecs[4]  = '{2'b10, 2'b10, 0, 0, 1, 0, 0, 0, 0, 0, 2'b11, 28'h20};
    vecs[5]  = '{2'b10, 2'b10, 1, 1, 0, 1, 0, 0, 1, 0, 2'b10, 28'h10};
    vecs[6]  = '{2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 28'h10};
    vecs[7]  = '{2'b10, 2'b10, 1, 1, 1, 0, 1, 0, 1, 0, 2'b10, 28'h20};
    vecs[8]  = '{2'b10, 2'b10, 0, 0, 1, 0, 0, 0, 0, 0, 2'b11, 28'h20};
    // Both masters withdraw while the last grant is in flight: it completes, nothing is forwarded.
    vecs[9]  = '{2'b11, 2'b11, 1, 1, 0, 0, 0, 0, 0, 0, 2'b10, 28'h10};
    vecs[10] = '{2'b11, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 28'h10};

    resetn = 1'b0;
    idleMasters();
    m0_addr = 28'h10; m1_addr = 28'h20;
    m0_wdata = 32'h0; m1_wdata = 32'h0;
    ds_rdata = 32'h0; ds_ready = 1'b0;

    @(negedge clk);
    checkOutput("reset ds_read_n", 32'(ds_read_n), 32'h3);
    checkOutput("reset ds_write_n", 32'(ds_write_n), 32'h3);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset owner", 32'(owner), 32'h1);
    checkOutput("reset timeout_err", 32'(timeout_err), 32'h0);
    checkOutput("reset ds_addr", 32'(ds_addr), 32'h0);
    checkOutput("reset ds_wdata", ds_wdata, 32'h0);

    nextCycle();
    resetn = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) nextCycle();
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkVector(i, vecs[i]);
    end

    // Single word read by m0 answered on the third BUSY cycle.
    nextCycle();
    ds_ready = 1'b0;
    m0_addr = 28'h0000100; m0_read_n = 2'b10;
    @(negedge clk);
    checkOutput("rd idle busy", 32'(busy), 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("rd busy", 32'(busy), 32'h1);
    checkOutput("rd owner", 32'(owner), 32'h0);
    checkOutput("rd ds_addr", 32'(ds_addr), 32'h100);
    checkOutput("rd ds_read_n", 32'(ds_read_n), 32'h2);
    checkOutput("rd early m0_ready", 32'(m0_ready), 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("rd wait m0_ready", 32'(m0_ready), 32'h0);
    nextCycle();
    ds_ready = 1'b1; ds_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checkOutput("rd m0_ready", 32'(m0_ready), 32'h1);
    checkOutput("rd m0_rdata", m0_rdata, 32'hDEADBEEF);
    checkOutput("rd m1_ready", 32'(m1_ready), 32'h0);
    checkOutput("rd m1_rdata", m1_rdata, 32'h0);
    nextCycle();
    ds_ready = 1'b0; m0_read_n = 2'b11;
    @(negedge clk);
    checkOutput("rd after ds_read_n", 32'(ds_read_n), 32'h3);
    checkOutput("rd after busy", 32'(busy), 32'h0);
    checkOutput("rd after m0_ready", 32'(m0_ready), 32'h0);

    // m1 byte write whose address and data change while it is outstanding.
    nextCycle();
    m1_addr = 28'h0000040; m1_wdata = 32'hA5; m1_write_n = 2'b00;
    nextCycle();
    m1_addr = 28'h00007FF; m1_wdata = 32'h11;
    @(negedge clk);
    checkOutput("wr owner", 32'(owner), 32'h1);
    checkOutput("wr ds_addr", 32'(ds_addr), 32'h40);
    checkOutput("wr ds_wdata", ds_wdata, 32'hA5);
    checkOutput("wr ds_write_n", 32'(ds_write_n), 32'h0);
    checkOutput("wr ds_read_n", 32'(ds_read_n), 32'h3);
    nextCycle();
    @(negedge clk);
    checkOutput("wr held ds_addr", 32'(ds_addr), 32'h40);
    checkOutput("wr held ds_write_n", 32'(ds_write_n), 32'h0);
    nextCycle();
    ds_ready = 1'b1;
    @(negedge clk);
    checkOutput("wr m1_ready", 32'(m1_ready), 32'h1);
    checkOutput("wr m0_ready", 32'(m0_ready), 32'h0);
    nextCycle();
    ds_ready = 1'b0; m1_write_n = 2'b11;
    @(negedge clk);
    checkOutput("wr after ds_write_n", 32'(ds_write_n), 32'h3);

    // ds_ready arriving on the very cycle the timeout would fire wins.
    nextCycle();
    m0_addr = 28'h0000300; m0_read_n = 2'b10;
    for (int k = 1; k <= 8; k++) begin
      nextCycle();
      if (k == 8) begin
        ds_ready = 1'b1; ds_rdata = 32'h12345678;
      end
      @(negedge clk);
      if (k == 7) checkOutput("to_race cyc7 m0_ready", 32'(m0_ready), 32'h0);
    end
    checkOutput("to_race m0_ready", 32'(m0_ready), 32'h1);
    checkOutput("to_race m0_rdata", m0_rdata, 32'h12345678);
    nextCycle();
    ds_ready = 1'b0; m0_read_n = 2'b11;
    @(negedge clk);
    checkOutput("to_race timeout_err", 32'(timeout_err), 32'h0);
    checkOutput("to_race busy", 32'(busy), 32'h0);

    // No ds_ready at all: the eighth BUSY cycle aborts with zero data.
    nextCycle();
    ds_rdata = 32'hFFFFFFFF; m0_read_n = 2'b10;
    for (int k = 1; k <= 8; k++) begin
      nextCycle();
      @(negedge clk);
      if (k == 7) checkOutput("to cyc7 m0_ready", 32'(m0_ready), 32'h0);
    end
    checkOutput("to m0_ready", 32'(m0_ready), 32'h1);
    checkOutput("to m0_rdata", m0_rdata, 32'h0);
    checkOutput("to m1_ready", 32'(m1_ready), 32'h0);
    nextCycle();
    m0_read_n = 2'b11;
    @(negedge clk);
    checkOutput("to timeout_err", 32'(timeout_err), 32'h1);
    checkOutput("to busy", 32'(busy), 32'h0);
    checkOutput("to ds_read_n", 32'(ds_read_n), 32'h3);
    nextCycle();
    @(negedge clk);
    checkOutput("to sticky timeout_err", 32'(timeout_err), 32'h1);

    // Asynchronous reset in the middle of a BUSY command.
    nextCycle();
    m0_addr = 28'h0000180; m0_read_n = 2'b10;
    nextCycle();
    @(negedge clk);
    checkOutput("rst pre busy", 32'(busy), 32'h1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("rst ds_read_n", 32'(ds_read_n), 32'h3);
    checkOutput("rst busy", 32'(busy), 32'h0);
    checkOutput("rst timeout_err", 32'(timeout_err), 32'h0);
    checkOutput("rst owner", 32'(owner), 32'h1);
    checkOutput("rst m0_ready", 32'(m0_ready), 32'h0);
    nextCycle();
    resetn = 1'b1; m0_addr = 28'h0000200;
    @(negedge clk);
    checkOutput("rst rel busy", 32'(busy), 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("rst grant busy", 32'(busy), 32'h1);
    checkOutput("rst grant owner", 32'(owner), 32'h0);
    checkOutput("rst grant ds_addr", 32'(ds_addr), 32'h200);
    checkOutput("rst grant ds_read_n", 32'(ds_read_n), 32'h2);
    nextCycle();
    ds_ready = 1'b1; ds_rdata = 32'h0BADF00D;
    @(negedge clk);
    checkOutput("rst done m0_ready", 32'(m0_ready), 32'h1);
    checkOutput("rst done m0_rdata", m0_rdata, 32'h0BADF00D);
    nextCycle();
    ds_ready = 1'b0; m0_read_n = 2'b11;
    @(negedge clk);
    checkOutput("rst done busy", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
